// File: rtl/keypad_pkg.sv
// ----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 keypad matrix emulator and its scanner benches:
// matrix dimensions, key index field layout, FSM state encoding and a one-hot
// line decode helper.
// ----------------------------------------------------------------------------
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  // Key index layout: row in the upper two bits, column in the lower two.
  localparam int KEY_ROW_MSB = 3;
  localparam int KEY_ROW_LSB = 2;
  localparam int KEY_COL_MSB = 1;
  localparam int KEY_COL_LSB = 0;

  typedef logic [3:0] key_t;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_BOUNCE_IN  = 2'd1,
    ST_HOLD       = 2'd2,
    ST_BOUNCE_OUT = 2'd3
  } kp_state_t;

  function automatic logic [1:0] key_row(input key_t key);
    key_row = key[KEY_ROW_MSB:KEY_ROW_LSB];
  endfunction

  function automatic logic [1:0] key_col(input key_t key);
    key_col = key[KEY_COL_MSB:KEY_COL_LSB];
  endfunction

  // One-hot decode of a 2-bit line index; rows and columns share the width.
  function automatic logic [ROWS-1:0] row_onehot(input logic [1:0] idx);
    row_onehot      = '0;
    row_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/keypad_bounce_timer.sv
// ----------------------------------------------------------------------------
// keypad_bounce_timer
// Step/phase counter that paces contact bounce. A start pulse begins phase 0;
// every BOUNCE_STEP cycles the phase index advances until BOUNCE_N phases have
// elapsed. Used once for make bounce and again for break bounce.
//
// Ports:
//   clk_50    in   system clock
//   rst_n     in   asynchronous reset, active-low
//   start     in   begin phase 0 at this edge
//   abort     in   stop and clear, wins over start
//   phase_odd out  parity of the phase that is in effect after the coming edge
//   last_end  out  high in the final cycle of the final phase
// ----------------------------------------------------------------------------
module keypad_bounce_timer #(
  parameter int BOUNCE_STEP = 4,
  parameter int BOUNCE_N    = 3
) (
  input  logic clk_50,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  output logic phase_odd,
  output logic last_end
);

  localparam int STEP_W  = $clog2(BOUNCE_STEP + 1);
  localparam int PH_W    = ($clog2(BOUNCE_N + 1) < 1) ? 1 : $clog2(BOUNCE_N + 1);
  localparam int LAST_PH = (BOUNCE_N > 0) ? BOUNCE_N - 1 : 0;

  logic              running;
  logic [STEP_W-1:0] step_cnt;
  logic [PH_W-1:0]   phase_idx;
  logic              step_last;
  logic              phase_last;

  assign step_last  = (step_cnt == STEP_W'(BOUNCE_STEP - 1));
  assign phase_last = (phase_idx == PH_W'(LAST_PH));
  assign last_end   = running & step_last & phase_last;

  // Look one edge ahead so the owner can register contact for the next phase.
  assign phase_odd  = (running & step_last) ? ~phase_idx[0] : phase_idx[0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      running   <= 1'b0;
      step_cnt  <= '0;
      phase_idx <= '0;
    end else if (abort) begin
      running   <= 1'b0;
      step_cnt  <= '0;
      phase_idx <= '0;
    end else if (start) begin
      running   <= 1'b1;
      step_cnt  <= '0;
      phase_idx <= '0;
    end else if (running) begin
      if (step_last) begin
        step_cnt <= '0;
        if (phase_last) begin
          running   <= 1'b0;
          phase_idx <= '0;
        end else begin
          phase_idx <= phase_idx + PH_W'(1);
        end
      end else begin
        step_cnt <= step_cnt + STEP_W'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_matrix_emulator.sv
// ----------------------------------------------------------------------------
// keypad_matrix_emulator
// Keypad side of a 4x4 row/column scan matrix. A command "presses" one key for
// a programmed hold time, optionally with deterministic make/break bounce, and
// col answers the scanner's row drive as a real switch closure would.
//
// Ports:
//   clk_50     in   system clock
//   rst_n      in   asynchronous reset, active-low
//   cmd_valid  in   press request
//   cmd_ready  out  high in IDLE; accept on cmd_valid & cmd_ready
//   cmd_key    in   key index {row[1:0], col[1:0]}
//   cmd_hold   in   stable-closed cycles (0 behaves as 1)
//   cmd_bounce in   enable bounce for this press
//   cmd_abort  in   release immediately, overrides every transition
//   row        in   row drive from scanner, active-high
//   col        out  column sense to scanner, active-high
//   contact    out  current switch closure
//   busy       out  press in progress
//   done       out  one-cycle pulse on normal completion
// ----------------------------------------------------------------------------
module keypad_matrix_emulator
  import keypad_pkg::*;
#(
  parameter int BOUNCE_STEP = 4,
  parameter int BOUNCE_N    = 3,
  parameter int HOLD_W      = 24
) (
  input  logic              clk_50,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_key,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic              cmd_bounce,
  input  logic              cmd_abort,
  input  logic [ROWS-1:0]   row,
  output logic [COLS-1:0]   col,
  output logic              contact,
  output logic              busy,
  output logic              done
);

  localparam bit HAS_BOUNCE = (BOUNCE_N > 0);

  kp_state_t         state;
  key_t              key_q;
  logic              bounce_en;
  logic [HOLD_W-1:0] hold_cnt;

  logic              accept;
  logic              use_bounce;
  logic              hold_end;
  logic              timer_start;
  logic              phase_odd;
  logic              last_end;
  logic [HOLD_W-1:0] hold_init;

  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign accept     = cmd_valid & cmd_ready & ~cmd_abort;
  assign use_bounce = cmd_bounce & HAS_BOUNCE;
  assign hold_end   = (state == ST_HOLD) && (hold_cnt == '0);

  // The hold counter holds "cycles remaining minus one", so a zero request
  // and a one request both give a single closed cycle.
  assign hold_init  = (cmd_hold == '0) ? '0 : cmd_hold - HOLD_W'(1);

  // One timer serves both bounce windows: make bounce starts on accept,
  // break bounce starts when the hold runs out.
  assign timer_start = (accept & use_bounce) | (hold_end & bounce_en);

  keypad_bounce_timer #(
    .BOUNCE_STEP (BOUNCE_STEP),
    .BOUNCE_N    (BOUNCE_N)
  ) u_bounce_timer (
    .clk_50    (clk_50),
    .rst_n     (rst_n),
    .start     (timer_start),
    .abort     (cmd_abort),
    .phase_odd (phase_odd),
    .last_end  (last_end)
  );

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      key_q     <= '0;
      bounce_en <= 1'b0;
      hold_cnt  <= '0;
      contact   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cmd_abort) begin
        state    <= ST_IDLE;
        hold_cnt <= '0;
        contact  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              key_q     <= cmd_key;
              bounce_en <= use_bounce;
              hold_cnt  <= hold_init;
              // Make bounce opens on a closed phase, so contact closes either way.
              contact   <= 1'b1;
              state     <= use_bounce ? ST_BOUNCE_IN : ST_HOLD;
            end
          end
          ST_BOUNCE_IN: begin
            if (last_end) begin
              state   <= ST_HOLD;
              contact <= 1'b1;
            end else begin
              contact <= ~phase_odd;
            end
          end
          ST_HOLD: begin
            if (hold_end) begin
              contact <= 1'b0;
              if (bounce_en) begin
                state <= ST_BOUNCE_OUT;
              end else begin
                state <= ST_IDLE;
                done  <= 1'b1;
              end
            end else begin
              hold_cnt <= hold_cnt - HOLD_W'(1);
            end
          end
          ST_BOUNCE_OUT: begin
            if (last_end) begin
              state   <= ST_IDLE;
              contact <= 1'b0;
              done    <= 1'b1;
            end else begin
              contact <= phase_odd;
            end
          end
          default: begin
            state   <= ST_IDLE;
            contact <= 1'b0;
          end
        endcase
      end
    end
  end

  // Matrix physics: the closed key connects its row line to its column line,
  // so any driven row pattern that includes the key's row shows up on col.
  // NOTE: col gets a default before the conditional assignment so this
  // combinational block cannot infer a latch.
  always_comb begin
    col = '0;
    if (contact && row[key_row(key_q)]) begin
      col = row_onehot(key_col(key_q));
    end
  end

endmodule
